// File: rtl/alu_issue_stage_if.sv
// Signal bundle between decode, the ALU issue stage and the ALU.
// The slave modport is the issue stage; the master modport is its environment.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [1:0]  in_src1_sel;
  logic [1:0]  in_src2_sel;
  logic        in_rd_we;

  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [31:0] out_src1;
  logic [31:0] out_src2;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  logic [31:0] ex_result;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ld_busy;
  logic [4:0]  ld_rd;
  logic        flush;
  logic [15:0] stall_cnt;

  modport master (
    output in_valid, in_alu_op, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_src1_sel, in_src2_sel, in_rd_we, out_ready,
           ex_result, wb_we, wb_rd, wb_data, ld_busy, ld_rd, flush,
    input  in_ready, out_valid, out_alu_op, out_src1, out_src2, out_rd, out_rd_we,
           stall_cnt
  );

  modport slave (
    input  in_valid, in_alu_op, in_rs1, in_rs2, in_rd, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_src1_sel, in_src2_sel, in_rd_we, out_ready,
           ex_result, wb_we, wb_rd, wb_data, ld_busy, ld_rd, flush,
    output in_ready, out_valid, out_alu_op, out_src1, out_src2, out_rd, out_rd_we,
           stall_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Single-entry ALU issue register with operand select, EX/WB forwarding,
// load-use hazard stalling and a saturating stall counter.
module alu_issue_stage #(
  parameter int unsigned FWD_EN = 1
) (
  input logic               clk,
  input logic               rst,
  alu_issue_stage_if.slave  bus
);

  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  logic        accept;
  logic        issue;
  logic        fwd_on;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] src1_nxt;
  logic [31:0] src2_nxt;

  assign fwd_on   = (FWD_EN != 0);
  assign uses_rs1 = (bus.in_src1_sel == 2'd0) || (bus.in_src1_sel == 2'd3);
  assign uses_rs2 = (bus.in_src2_sel == 2'd0) || (bus.in_src2_sel == 2'd3);

  assign hazard = bus.ld_busy && (bus.ld_rd != 5'd0) &&
                  ((uses_rs1 && (bus.in_rs1 == bus.ld_rd)) ||
                   (uses_rs2 && (bus.in_rs2 == bus.ld_rd)));

  assign issue        = bus.out_valid && bus.out_ready;
  assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready) && !hazard && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // The EX result only forwards when the producer actually leaves this stage this cycle.
  always_comb begin
    rs1_val = bus.in_rs1_data;
    if (bus.in_rs1 == 5'd0)
      rs1_val = '0;
    else if (fwd_on && issue && bus.out_rd_we && (bus.out_rd == bus.in_rs1))
      rs1_val = bus.ex_result;
    else if (fwd_on && bus.wb_we && (bus.wb_rd == bus.in_rs1))
      rs1_val = bus.wb_data;

    rs2_val = bus.in_rs2_data;
    if (bus.in_rs2 == 5'd0)
      rs2_val = '0;
    else if (fwd_on && issue && bus.out_rd_we && (bus.out_rd == bus.in_rs2))
      rs2_val = bus.ex_result;
    else if (fwd_on && bus.wb_we && (bus.wb_rd == bus.in_rs2))
      rs2_val = bus.wb_data;
  end

  always_comb begin
    src1_nxt = rs1_val;
    case (bus.in_src1_sel)
      2'd1:    src1_nxt = bus.in_pc;
      2'd2:    src1_nxt = 32'h0;
      default: src1_nxt = rs1_val;
    endcase

    src2_nxt = rs2_val;
    case (bus.in_src2_sel)
      2'd1:    src2_nxt = bus.in_imm;
      2'd2:    src2_nxt = 32'h4;
      default: src2_nxt = rs2_val;
    endcase
  end

  // Flush wins over accept/issue; in_ready is already low during flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_alu_op <= '0;
      bus.out_src1   <= '0;
      bus.out_src2   <= '0;
      bus.out_rd     <= '0;
      bus.out_rd_we  <= 1'b0;
      bus.stall_cnt  <= '0;
    end else begin
      if (bus.in_valid && hazard && !bus.flush && (bus.stall_cnt != 16'hFFFF))
        bus.stall_cnt <= bus.stall_cnt + 16'd1;

      if (bus.flush) begin
        bus.out_valid <= 1'b0;
      end else if (accept) begin
        bus.out_valid  <= 1'b1;
        bus.out_alu_op <= bus.in_alu_op;
        bus.out_src1   <= src1_nxt;
        bus.out_src2   <= src2_nxt;
        bus.out_rd     <= bus.in_rd;
        bus.out_rd_we  <= bus.in_rd_we;
      end else if (issue) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the issue register.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.FWD_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: the instruction currently held, if any.
  logic        m_valid;
  logic [3:0]  m_op;
  logic [31:0] m_src1;
  logic [31:0] m_src2;
  logic [4:0]  m_rd;
  logic        m_we;
  int          m_stall;

  function automatic logic reads_reg(input logic [1:0] sel);
    return (sel == 2'd0) || (sel == 2'd3);
  endfunction

  function automatic logic ref_hazard();
    return bus.ld_busy && (bus.ld_rd != 0) &&
           ((reads_reg(bus.in_src1_sel) && bus.in_rs1 == bus.ld_rd) ||
            (reads_reg(bus.in_src2_sel) && bus.in_rs2 == bus.ld_rd));
  endfunction

  function automatic logic ref_ready();
    return !rst && (!m_valid || bus.out_ready) && !ref_hazard() && !bus.flush;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'h0;
    if (m_valid && bus.out_ready && m_we && m_rd == r) return bus.ex_result;
    if (bus.wb_we && bus.wb_rd == r) return bus.wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_src1();
    if (bus.in_src1_sel == 2'd1) return bus.in_pc;
    if (bus.in_src1_sel == 2'd2) return 32'h0;
    return ref_operand(bus.in_rs1, bus.in_rs1_data);
  endfunction

  function automatic logic [31:0] ref_src2();
    if (bus.in_src2_sel == 2'd1) return bus.in_imm;
    if (bus.in_src2_sel == 2'd2) return 32'h4;
    return ref_operand(bus.in_rs2, bus.in_rs2_data);
  endfunction

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    logic        n_valid = m_valid;
    logic [3:0]  n_op    = m_op;
    logic [31:0] n_src1  = m_src1;
    logic [31:0] n_src2  = m_src2;
    logic [4:0]  n_rd    = m_rd;
    logic        n_we    = m_we;
    int          n_stall = m_stall;
    if (rst) begin
      n_valid = 0; n_op = 0; n_src1 = 0; n_src2 = 0; n_rd = 0; n_we = 0; n_stall = 0;
    end else begin
      if (bus.in_valid && ref_hazard() && !bus.flush && n_stall < 65535) n_stall++;
      if (bus.flush) n_valid = 0;
      else if (bus.in_valid && ref_ready()) begin
        n_valid = 1; n_op = bus.in_alu_op; n_src1 = ref_src1(); n_src2 = ref_src2();
        n_rd = bus.in_rd; n_we = bus.in_rd_we;
      end else if (m_valid && bus.out_ready) n_valid = 0;
    end
    @(posedge clk);
    m_valid = n_valid; m_op = n_op; m_src1 = n_src1; m_src2 = n_src2;
    m_rd = n_rd; m_we = n_we; m_stall = n_stall;
    #1;
  endtask

  task automatic set_idle();
    bus.in_valid = 0; bus.in_alu_op = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
    bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0; bus.in_pc = 0;
    bus.in_src1_sel = 0; bus.in_src2_sel = 0; bus.in_rd_we = 0; bus.out_ready = 1;
    bus.ex_result = 0; bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.ld_busy = 0; bus.ld_rd = 0; bus.flush = 0;
  endtask

  task automatic set_instr(input logic [4:0] rd, input logic [1:0] s1, input logic [31:0] pc,
                           input logic [1:0] s2, input logic [31:0] imm);
    bus.in_valid = 1; bus.in_alu_op = rd[3:0]; bus.in_rd = rd; bus.in_rd_we = 1;
    bus.in_src1_sel = s1; bus.in_pc = pc; bus.in_src2_sel = s2; bus.in_imm = imm;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_idle(); rst = 1; bus.in_valid = 1; bus.in_rd = 5'd9;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fails++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", bus.in_ready);
    end
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_alu_op, bus.out_src1, bus.out_src2, bus.out_rd, bus.out_rd_we} !== '0) begin
      n_fails++; $display("[TB] FAIL reset_outputs: got valid=%0b src1=%0h src2=%0h rd=%0d expected all 0",
                          bus.out_valid, bus.out_src1, bus.out_src2, bus.out_rd);
    end
    n_checks++;
    if (bus.stall_cnt !== 16'h0) begin
      n_fails++; $display("[TB] FAIL reset_stall_cnt: got %0h expected 0", bus.stall_cnt);
    end
    @(negedge clk);
    rst = 0; set_idle();
    tick();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    set_idle();
    set_instr(5'd5, 2'd0, 0, 2'd0, 0);
    bus.in_alu_op = 4'd0; bus.in_rs1 = 5'd1; bus.in_rs1_data = 32'h1;
    bus.in_rs2 = 5'd2; bus.in_rs2_data = 32'h2;
    tick();
    @(negedge clk);
    set_instr(5'd6, 2'd0, 0, 2'd1, 32'h9);
    bus.in_rs1 = 5'd5; bus.in_rs1_data = 32'h0; bus.ex_result = 32'h10;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fails++; $display("[TB] FAIL fwd_in_ready: got %0b expected 1", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.out_src1 !== 32'h10 || m_src1 !== 32'h10) begin
      n_fails++; $display("[TB] FAIL ex_forward: got %0h expected 10", bus.out_src1);
    end
  endtask

  task automatic test_wb_forwarding();
    @(negedge clk);
    set_idle();
    set_instr(5'd8, 2'd2, 0, 2'd0, 0);
    bus.in_rs2 = 5'd3; bus.in_rs2_data = 32'h55;
    bus.wb_we = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'hAA;
    tick();
    n_checks++;
    if (bus.out_src2 !== 32'hAA) begin
      n_fails++; $display("[TB] FAIL wb_forward: got %0h expected aa", bus.out_src2);
    end
    @(negedge clk);
    bus.in_rs2 = 5'd0; bus.wb_rd = 5'd0; bus.in_rd = 5'd9;
    tick();
    n_checks++;
    if (bus.out_src2 !== 32'h0) begin
      n_fails++; $display("[TB] FAIL x0_rule: got %0h expected 0", bus.out_src2);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_idle(); rst = 1;
    tick();
    @(negedge clk);
    rst = 0;
    set_instr(5'd4, 2'd0, 32'h400, 2'd1, 32'h1);
    bus.in_rs1 = 5'd7; bus.in_rs1_data = 32'h1234;
    bus.ld_busy = 1; bus.ld_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fails++; $display("[TB] FAIL load_use_stall[%0d]: got %0b expected 0", i, bus.in_ready);
      end
      tick();
    end
    n_checks++;
    if (bus.stall_cnt !== 16'd3 || bus.out_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL stall_cnt_3: got cnt=%0d valid=%0b expected cnt=3 valid=0",
                          bus.stall_cnt, bus.out_valid);
    end
    @(negedge clk);
    bus.ld_busy = 0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fails++; $display("[TB] FAIL load_release_ready: got %0b expected 1", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_src1 !== 32'h1234) begin
      n_fails++; $display("[TB] FAIL load_release_accept: got valid=%0b src1=%0h expected 1/1234",
                          bus.out_valid, bus.out_src1);
    end
    @(negedge clk);
    bus.ld_busy = 1; bus.in_src1_sel = 2'd1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fails++; $display("[TB] FAIL pc_sel_no_stall: got %0b expected 1", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.out_src1 !== 32'h400 || bus.stall_cnt !== 16'd3) begin
      n_fails++; $display("[TB] FAIL pc_sel_issue: got src1=%0h cnt=%0d expected 400/3",
                          bus.out_src1, bus.stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_idle();
    set_instr(5'd10, 2'd1, 32'h100, 2'd2, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.out_ready = 0;
      set_instr(5'd11, 2'd1, 32'h200, 2'd1, 32'h33);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fails++; $display("[TB] FAIL backpressure_ready[%0d]: got %0b expected 0", i, bus.in_ready);
      end
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_rd, bus.out_src1, bus.out_src2} !== {1'b1, 5'd10, 32'h100, 32'h4}) begin
        n_fails++; $display("[TB] FAIL backpressure_hold[%0d]: got rd=%0d src1=%0h src2=%0h expected 10/100/4",
                            i, bus.out_rd, bus.out_src1, bus.out_src2);
      end
    end
    @(negedge clk);
    bus.out_ready = 1;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_rd, bus.out_src1, bus.out_src2} !== {1'b1, 5'd11, 32'h200, 32'h33}) begin
      n_fails++; $display("[TB] FAIL back_to_back_1: got valid=%0b rd=%0d src1=%0h expected 1/11/200",
                          bus.out_valid, bus.out_rd, bus.out_src1);
    end
    @(negedge clk);
    set_instr(5'd12, 2'd1, 32'h300, 2'd2, 32'h0);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd12) begin
      n_fails++; $display("[TB] FAIL back_to_back_2: got valid=%0b rd=%0d expected 1/12", bus.out_valid, bus.out_rd);
    end
    @(negedge clk);
    bus.in_valid = 0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL drain: got %0b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_flush_reset();
    @(negedge clk);
    set_idle();
    set_instr(5'd13, 2'd1, 32'h500, 2'd2, 32'h0);
    tick();
    @(negedge clk);
    bus.out_ready = 0; bus.flush = 1;
    set_instr(5'd14, 2'd1, 32'h600, 2'd2, 32'h0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fails++; $display("[TB] FAIL flush_ready: got %0b expected 0", bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL flush_clear: got %0b expected 0", bus.out_valid);
    end
    @(negedge clk);
    bus.flush = 0; bus.in_valid = 0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL flush_no_accept: got %0b expected 0", bus.out_valid);
    end
    @(negedge clk);
    set_instr(5'd15, 2'd1, 32'h700, 2'd1, 32'h77);
    tick();
    @(negedge clk);
    bus.in_valid = 0; rst = 1;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_alu_op, bus.out_src1, bus.out_src2, bus.out_rd, bus.out_rd_we} !== '0) begin
      n_fails++; $display("[TB] FAIL reset_while_holding: got valid=%0b rd=%0d src1=%0h expected all 0",
                          bus.out_valid, bus.out_rd, bus.out_src1);
    end
    @(negedge clk);
    rst = 0; bus.out_ready = 1;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL reset_no_reissue: got %0b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 63) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_alu_op = 4'($urandom); bus.in_rd = 5'($urandom_range(0, 7));
      bus.in_rs1 = 5'($urandom_range(0, 7)); bus.in_rs2 = 5'($urandom_range(0, 7));
      bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom;
      bus.in_imm = $urandom; bus.in_pc = $urandom;
      bus.in_src1_sel = 2'($urandom); bus.in_src2_sel = 2'($urandom);
      bus.in_rd_we = 1'($urandom); bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.ex_result = $urandom; bus.wb_we = 1'($urandom);
      bus.wb_rd = 5'($urandom_range(0, 7)); bus.wb_data = $urandom;
      bus.ld_busy = ($urandom_range(0, 2) == 0); bus.ld_rd = 5'($urandom_range(0, 7));
      bus.flush = ($urandom_range(0, 15) == 0);
      #1;
      n_checks++;
      if (bus.in_ready !== ref_ready()) begin
        n_fails++; $display("[TB] FAIL rand_ready[%0d]: got %0b expected %0b", i, bus.in_ready, ref_ready());
      end
      tick();
      n_checks++;
      if (bus.out_valid !== m_valid || bus.stall_cnt !== 16'(m_stall)) begin
        n_fails++; $display("[TB] FAIL rand_state[%0d]: got valid=%0b cnt=%0d expected %0b/%0d",
                            i, bus.out_valid, bus.stall_cnt, m_valid, m_stall);
      end
      if (m_valid) begin
        n_checks++;
        if ({bus.out_alu_op, bus.out_src1, bus.out_src2, bus.out_rd, bus.out_rd_we} !==
            {m_op, m_src1, m_src2, m_rd, m_we}) begin
          n_fails++; $display("[TB] FAIL rand_entry[%0d]: got op=%0h s1=%0h s2=%0h rd=%0d we=%0b expected op=%0h s1=%0h s2=%0h rd=%0d we=%0b",
                              i, bus.out_alu_op, bus.out_src1, bus.out_src2, bus.out_rd, bus.out_rd_we,
                              m_op, m_src1, m_src2, m_rd, m_we);
        end
      end
    end
    @(negedge clk);
    rst = 0; set_idle();
    tick();
  endtask

  task automatic test_saturation();
    @(negedge clk);
    set_idle(); rst = 1;
    tick();
    @(negedge clk);
    rst = 0;
    set_instr(5'd2, 2'd3, 0, 2'd1, 0);
    bus.in_rs1 = 5'd9; bus.ld_busy = 1; bus.ld_rd = 5'd9;
    for (int i = 0; i < 65540; i++) tick();
    n_checks++;
    if (bus.stall_cnt !== 16'hFFFF || m_stall != 65535) begin
      n_fails++; $display("[TB] FAIL stall_saturate: got %0h expected ffff", bus.stall_cnt);
    end
    tick();
    n_checks++;
    if (bus.stall_cnt !== 16'hFFFF || bus.out_valid !== 1'b0) begin
      n_fails++; $display("[TB] FAIL stall_hold_sat: got cnt=%0h valid=%0b expected ffff/0",
                          bus.stall_cnt, bus.out_valid);
    end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    m_valid = 0; m_op = 0; m_src1 = 0; m_src2 = 0; m_rd = 0; m_we = 0; m_stall = 0;
    rst = 1;
    set_idle();
    test_reset();
    test_forwarding();
    test_wb_forwarding();
    test_load_use();
    test_back_to_back();
    test_flush_reset();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter FWD_EN, default 1: 1 enables operand forwarding; 0 takes all register operands from in_rs*_data.
REQ-002 The block SHALL use one clock and synchronous, active-high reset, exactly as follows.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  decoded-instruction handshake from decode.
REQ-006 in_alu_op  in  4  ALU operation code, passed through unchanged.
REQ-007 in_rs1, in_rs2, in_rd  in  5 each  source and destination register indices.
REQ-008 in_rs1_data, in_rs2_data, in_imm, in_pc  in  32 each  register-file read data, immediate and PC.
REQ-009 in_src1_sel  in  2  source 1 select: 0 = rs1, 1 = pc, 2 = 32'h0, 3 = rs1.
REQ-010 in_src2_sel  in  2  source 2 select: 0 = rs2, 1 = imm, 2 = 32'h4, 3 = rs2.
REQ-011 in_rd_we  in  1  destination write enable.
REQ-012 out_valid / out_ready  out / in  1 / 1  issue handshake to the ALU.
REQ-013 out_alu_op (4), out_src1 (32), out_src2 (32), out_rd (5), out_rd_we (1)  out  registered ALU operands and tags.
REQ-014 ex_result  in  32  combinational ALU result for the instruction currently held in this stage.
REQ-015 wb_we (1), wb_rd (5), wb_data (32)  in  writeback port.
REQ-016 ld_busy (1), ld_rd (5)  in  load outstanding in memory and its destination.
REQ-017 flush  in  1  discard held and incoming instruction.
REQ-018 stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-019 Single-entry pipeline register: accept = in_valid && in_ready; issue = out_valid && out_ready.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush, combinationally.
REQ-021 hazard SHALL be ld_busy && ld_rd != 0 && ((uses_rs1 && in_rs1 == ld_rd) || (uses_rs2 && in_rs2 == ld_rd)), where uses_rs1 = src1_sel in {0,3} and uses_rs2 = src2_sel in {0,3}.
REQ-022 Register operand value for index r SHALL be:
- 0 if r == 0;
- else ex_result if FWD_EN && issue && out_rd_we && out_rd == r;
- else wb_data if FWD_EN && wb_we && wb_rd == r;
- else the in_rs*_data value.
REQ-023 On accept, out_* SHALL load the selected operands and tags at the next edge, and out_valid SHALL be 1.
REQ-024 On issue without accept, out_valid SHALL clear at the next edge.
REQ-025 When out_valid && !out_ready, all out_* SHALL hold stable.
REQ-026 Simultaneous issue and accept SHALL replace the entry with no bubble.
REQ-027 Latency: one cycle, accept to out_valid.
REQ-028 Full throughput: one instruction per cycle when out_ready is held at 1.
REQ-029 flush SHALL clear out_valid at the next edge regardless of out_ready.
REQ-030 No instruction is accepted in a flush cycle.
REQ-031 stall_cnt SHALL increment by 1 each cycle with in_valid && hazard && !flush, saturating at 16'hFFFF.
REQ-032 Priority SHALL be rst > flush > issue/accept.

Reset
REQ-033 While rst = 1 at an edge: out_valid = 0, stall_cnt = 0, and out_alu_op, out_src1, out_src2, out_rd, out_rd_we = 0.
REQ-034 in_ready SHALL be 0 while rst is asserted.
REQ-035 Reset asserted mid-stall or while holding an entry SHALL discard that entry; the held entry is not issued afterwards.

Verification
REQ-036 Forwarding: ADD rd=5 held with ex_result = 32'h10, out_ready = 1; next instruction rs1 = 5, rs1_data = 32'h0 -> out_src1 = 32'h10 the following cycle.
REQ-037 WB forwarding and x0 rule:
- wb_we = 1, wb_rd = 3, wb_data = 32'hAA; in_rs2 = 3, src2_sel = 0 -> out_src2 = 32'hAA.
- Same with in_rs2 = 0 and wb_rd = 0 -> out_src2 = 0.
REQ-038 Load-use:
- ld_busy = 1, ld_rd = 7; in_rs1 = 7 valid for 3 cycles -> in_ready = 0 for those 3 cycles, stall_cnt = 3.
- Dropping ld_busy -> accepted next edge.
- src1_sel = 1 (pc) with the same rs1 -> no stall.
REQ-039 Backpressure: out_ready = 0 for 4 cycles while holding -> out_* stable; then out_ready = 1 with in_valid = 1 -> back-to-back issue, no bubble.
REQ-040 Flush and reset:
- flush with out_valid = 1, out_ready = 0 -> out_valid = 0 next cycle, input not accepted.
- rst pulse while holding -> all outputs 0.
- stall_cnt at 16'hFFFF stays saturated under further stalls.
